// File: rtl/weight_server.sv
// Binary weight bus server: stores one conv kernel set plus FC_ROWS FC sets loaded
// over a valid/ready stream, and steps through them on each weight_req pulse.
module weight_server #(
   parameter int unsigned K       = 4,
   parameter int unsigned CH_NUM  = 6,
   parameter int unsigned FC_ROWS = 10,
   parameter int unsigned CNT_W   = 7
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     load_valid,
   output logic                     load_ready,
   input  logic [K*K-1:0]           load_data,
   input  logic                     reload_req,
   input  logic                     weight_req,
   output logic [CH_NUM*K*K-1:0]    weight,
   output logic                     weight_valid,
   output logic [CNT_W-1:0]         fc_idx,
   output logic                     req_err
);

   localparam int unsigned KK     = K * K;
   localparam int unsigned SET_W  = CH_NUM * KK;
   localparam int unsigned SLOTS  = (FC_ROWS + 1) * CH_NUM;
   localparam int unsigned SLOT_W = $clog2(SLOTS);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_LOAD  = 2'd1,
      S_SERVE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [SET_W-1:0]   weight_q, weight_d;
   logic               valid_q, valid_d;
   logic [CNT_W-1:0]   fc_idx_q, fc_idx_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic               req_err_q, req_err_d;
   logic               pending_q, pending_d;
   logic               ready_q, ready_d;

   logic [KK-1:0]      mem_q [SLOTS];
   logic               mem_we_c;
   logic [CNT_W-1:0]   set_sel_c;
   logic [SET_W-1:0]   set_c;

   // Set picked for the next update: FC set fc_idx while mid-frame, conv set otherwise
   always_comb begin
      set_sel_c = '0;
      set_c     = '0;
      if (state_q == S_SERVE && fc_idx_q < CNT_W'(FC_ROWS)) begin
         set_sel_c = fc_idx_q + CNT_W'(1);
      end
      for (int unsigned c = 0; c < CH_NUM; c++) begin
         set_c[c*KK +: KK] = mem_q[SLOT_W'(32'(set_sel_c) * CH_NUM + c)];
      end
   end

   always_comb begin
      state_d    = state_q;
      weight_d   = weight_q;
      valid_d    = valid_q;
      fc_idx_d   = fc_idx_q;
      beat_cnt_d = beat_cnt_q;
      req_err_d  = req_err_q;
      pending_d  = pending_q;
      mem_we_c   = 1'b0;

      case (state_q)
         S_EMPTY, S_LOAD: begin
            if (weight_req) begin
               req_err_d = 1'b1;
            end
            if (load_valid && ready_q) begin
               mem_we_c = 1'b1;
               if (beat_cnt_q == CNT_W'(SLOTS - 1)) begin
                  state_d    = S_SERVE;
                  weight_d   = set_c;
                  valid_d    = 1'b1;
                  fc_idx_d   = '0;
                  beat_cnt_d = '0;
               end else begin
                  state_d    = S_LOAD;
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end
         end
         S_SERVE: begin
            if (weight_req) begin
               weight_d = set_c;
               fc_idx_d = (fc_idx_q < CNT_W'(FC_ROWS)) ? fc_idx_q + CNT_W'(1) : '0;
               if (reload_req) begin
                  pending_d = 1'b1;
               end
            end else if (pending_q && fc_idx_q == '0) begin
               // Reload only between frames; weight keeps its last value
               state_d   = S_EMPTY;
               valid_d   = 1'b0;
               pending_d = 1'b0;
            end else if (reload_req) begin
               pending_d = 1'b1;
            end
         end
         default: begin
            state_d = S_EMPTY;
         end
      endcase

      ready_d = (state_d != S_SERVE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= S_EMPTY;
         weight_q   <= '0;
         valid_q    <= 1'b0;
         fc_idx_q   <= '0;
         beat_cnt_q <= '0;
         req_err_q  <= 1'b0;
         pending_q  <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         weight_q   <= weight_d;
         valid_q    <= valid_d;
         fc_idx_q   <= fc_idx_d;
         beat_cnt_q <= beat_cnt_d;
         req_err_q  <= req_err_d;
         pending_q  <= pending_d;
         ready_q    <= ready_d;
      end
   end

   // Weight storage survives reset
   always_ff @(posedge clk) begin
      if (rstn && mem_we_c) begin
         mem_q[SLOT_W'(beat_cnt_q)] <= load_data;
      end
   end

   assign load_ready   = ready_q;
   assign weight       = weight_q;
   assign weight_valid = valid_q;
   assign fc_idx       = fc_idx_q;
   assign req_err      = req_err_q;

endmodule

// File: tb/tb_weight_server.sv
// Scoreboard bench for weight_server: stimulus pushes expected outputs tagged with
// the cycle they must appear in; a negedge monitor pops and compares.
module tb_weight_server;

   localparam int unsigned KK = 16;
   localparam int unsigned WW = 96;
   localparam int unsigned CW = 7;

   logic          clk;
   logic          rstn;
   logic          load_valid;
   logic          load_ready;
   logic [KK-1:0] load_data;
   logic          reload_req;
   logic          weight_req;
   logic [WW-1:0] weight;
   logic          weight_valid;
   logic [CW-1:0] fc_idx;
   logic          req_err;

   weight_server dut (
      .clk          (clk),
      .rstn         (rstn),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_data    (load_data),
      .reload_req   (reload_req),
      .weight_req   (weight_req),
      .weight       (weight),
      .weight_valid (weight_valid),
      .fc_idx       (fc_idx),
      .req_err      (req_err)
   );

   typedef struct {
      int unsigned   tag;
      logic [WW-1:0] w;
      logic          v;
      logic [CW-1:0] fc;
      logic          err;
      logic          rdy;
   } exp_t;

   exp_t  exp_q [$];
   string nm_q [$];

   int unsigned cyc    = 0;
   int unsigned checks = 0;
   int unsigned fails  = 0;

   logic [WW-1:0] e_w;
   logic          e_v;
   logic [CW-1:0] e_fc;
   logic          e_err;
   logic          e_rdy;

   exp_t  m_e;
   string m_nm;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Set s channel c was loaded with beat index s*6+c
   function automatic logic [WW-1:0] set_val(input int s);
      logic [WW-1:0] r;
      r = '0;
      for (int c = 0; c < 6; c++) r[c*KK +: KK] = 16'(s * 6 + c);
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string nm);
      exp_t e;
      e.tag = cyc + 1;
      e.w   = e_w;
      e.v   = e_v;
      e.fc  = e_fc;
      e.err = e_err;
      e.rdy = e_rdy;
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
         m_e  = exp_q.pop_front();
         m_nm = nm_q.pop_front();
         checks++;
         if (m_e.tag != cyc) begin
            fails++;
            $display("FAIL %s: check for cyc %0d not taken until cyc %0d", m_nm, m_e.tag, cyc);
         end else if (weight !== m_e.w || weight_valid !== m_e.v || fc_idx !== m_e.fc ||
                      req_err !== m_e.err || load_ready !== m_e.rdy) begin
            fails++;
            $display("FAIL %s @cyc %0d: got w=%h v=%b fc=%0d err=%b rdy=%b, expected w=%h v=%b fc=%0d err=%b rdy=%b",
                     m_nm, cyc, weight, weight_valid, fc_idx, req_err, load_ready,
                     m_e.w, m_e.v, m_e.fc, m_e.err, m_e.rdy);
         end
      end
   end

   task automatic do_reset(input int cycles);
      rstn  = 1'b0;
      e_w   = '0;
      e_v   = 1'b0;
      e_fc  = '0;
      e_err = 1'b0;
      e_rdy = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         push("reset");
         step();
      end
      rstn       = 1'b1;
      load_valid = 1'b0;
   endtask

   // Stream beats 0..n-1 with data = beat index; optional stalls, error request, ignored reload
   task automatic load_beats(input int n, input bit stall, input int err_beat, input int rel_beat);
      for (int b = 0; b < n; b++) begin
         if (stall && (b % 7 == 3)) begin
            for (int g = 0; g < 1 + (b % 2); g++) begin
               load_valid = 1'b0;
               load_data  = 16'hFFFF;
               push("load_stall");
               step();
            end
         end
         load_valid = 1'b1;
         load_data  = 16'(b);
         weight_req = (b == err_beat);
         reload_req = (b == rel_beat);
         if (b == err_beat) e_err = 1'b1;
         if (b == 65) begin
            e_w   = set_val(0);
            e_v   = 1'b1;
            e_fc  = '0;
            e_rdy = 1'b0;
         end
         push((b == 65) ? "load_done" : (b == err_beat) ? "req_in_load" : "load_beat");
         step();
      end
      load_valid = 1'b0;
      weight_req = 1'b0;
      reload_req = 1'b0;
   endtask

   // One frame of 11 requests; mode 1 = reload at fc_idx 4, mode 2 = reload with last request
   task automatic frame(input int gap, input int mode, input bit junk);
      for (int k = 0; k <= 10; k++) begin
         weight_req = 1'b1;
         reload_req = (mode == 2 && k == 10);
         if (k < 10) begin
            e_w  = set_val(k + 1);
            e_fc = 7'(k + 1);
         end else begin
            e_w  = set_val(0);
            e_fc = '0;
         end
         push((k < 10) ? "fc_req" : "frame_wrap");
         step();
         weight_req = 1'b0;
         reload_req = 1'b0;
         for (int i = 1; i < gap; i++) begin
            reload_req = (mode == 1 && k == 3 && i == 1);
            load_valid = junk;
            load_data  = 16'hBEEF;
            if (mode != 0 && k == 10 && i == 1) begin
               e_v   = 1'b0;
               e_rdy = 1'b1;
            end
            push((mode != 0 && k == 10 && i == 1) ? "reload_taken" : "hold");
            step();
         end
         reload_req = 1'b0;
         load_valid = 1'b0;
      end
      push("idle");
      step();
   endtask

   initial begin
      rstn       = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      reload_req = 1'b0;
      weight_req = 1'b0;

      do_reset(2);
      load_beats(66, 1'b0, -1, -1);
      frame(2, 0, 1'b1);
      frame(1, 0, 1'b0);
      frame(2, 1, 1'b0);
      load_beats(66, 1'b1, 20, -1);
      frame(2, 2, 1'b0);
      load_beats(30, 1'b0, -1, -1);
      load_valid = 1'b1;
      load_data  = 16'd30;
      do_reset(1);
      load_beats(66, 1'b0, -1, 10);
      frame(2, 0, 1'b1);

      step();
      step();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
